seg7_pattern_reader: RTL and testbench

Receive-side monitor for the alarm display path: samples the seven segment lines A–G driven by the display blocks, debounces them, and decodes each accepted pattern into a 5-bit symbol code. It also detects blinking, meaning a lit pattern alternating with blank, and reports the underlying symbol. The block sits beside the display drivers and feeds status/self-check logic and testbench scoreboards.

---
 rtl/seg7_codes_pkg.sv | 34 +++
 rtl/seg7_to_code.sv | 32 +++
 rtl/seg7_pattern_reader.sv | 167 ++++++++++++++++
 tb/tb_seg7_pattern_reader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_codes_pkg.sv
// Shared constants for the seven-segment pattern reader: segment patterns
// ({A,B,C,D,E,F,G}, A is the MSB), symbol codes and the blink-tracking states.
package seg7_codes_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_U     = 7'b0111110;
    localparam logic [6:0] SEG_P     = 7'b1100111;
    localparam logic [6:0] SEG_MARK  = 7'b1110100;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [4:0] CODE_U       = 5'h0A;
    localparam logic [4:0] CODE_P       = 5'h0B;
    localparam logic [4:0] CODE_MARK    = 5'h0C;
    localparam logic [4:0] CODE_BLANK   = 5'h1E;
    localparam logic [4:0] CODE_INVALID = 5'h1F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LIT,
        ST_DARK,
        ST_BLINK_LIT,
        ST_BLINK_DARK
    } blink_state_t;

endpackage

// File: rtl/seg7_to_code.sv
// Pure combinational lookup from a 7-bit segment pattern to its 5-bit symbol
// code; anything not in the symbol table is reported as INVALID.
module seg7_to_code
    import seg7_codes_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic [4:0] o_code
);

    // Table lookup, INVALID for every unlisted pattern
    always_comb begin
        o_code = CODE_INVALID;
        case (i_pat)
            SEG_0:     o_code = 5'h00;
            SEG_1:     o_code = 5'h01;
            SEG_2:     o_code = 5'h02;
            SEG_3:     o_code = 5'h03;
            SEG_4:     o_code = 5'h04;
            SEG_5:     o_code = 5'h05;
            SEG_6:     o_code = 5'h06;
            SEG_7:     o_code = 5'h07;
            SEG_8:     o_code = 5'h08;
            SEG_9:     o_code = 5'h09;
            SEG_U:     o_code = CODE_U;
            SEG_P:     o_code = CODE_P;
            SEG_MARK:  o_code = CODE_MARK;
            SEG_BLANK: o_code = CODE_BLANK;
            default:   o_code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/seg7_pattern_reader.sv
// Receive-side monitor for the display segment lines: debounces the sampled
// pattern, reports each newly accepted symbol, and tracks lit/blank
// alternation to flag blinking and the symbol being blinked.
module seg7_pattern_reader
    import seg7_codes_pkg::*;
#(
    parameter int STABLE_CYCLES = 1,
    parameter int BLINK_WINDOW  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       F,
    input  logic       G,
    output logic [4:0] code,
    output logic       code_valid,
    output logic [4:0] disp_code,
    output logic       blinking
);

    localparam int STAB_W  = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam int PHASE_W = $clog2(BLINK_WINDOW + 2);

    localparam logic [STAB_W-1:0]  STAB_MAX  = STAB_W'(STABLE_CYCLES);
    localparam logic [PHASE_W-1:0] PHASE_LIM = PHASE_W'(BLINK_WINDOW);
    localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(BLINK_WINDOW + 1);

    logic [6:0]         w_seg;
    logic [4:0]         w_code;
    logic               w_accept;
    logic               w_isBlank;
    logic               w_inWindow;
    logic               w_timeout;
    logic               w_relatch;
    blink_state_t       w_nextState;

    logic [6:0]         r_segQ;
    logic [STAB_W-1:0]  r_stabCnt;
    logic [6:0]         r_accPat;
    logic [PHASE_W-1:0] r_phaseCnt;
    logic [6:0]         r_litPat;
    blink_state_t       r_state;

    assign w_seg      = {A, B, C, D, E, F, G};
    assign w_accept   = (r_stabCnt == STAB_MAX) && (r_segQ != r_accPat);
    assign w_isBlank  = (r_segQ == SEG_BLANK);
    assign w_inWindow = (r_phaseCnt <= PHASE_LIM);
    assign w_timeout  = (r_phaseCnt == PHASE_MAX);

    seg7_to_code u_decode (
        .i_pat  (r_segQ),
        .o_code (w_code)
    );

    // Sample the segment lines and count how long the sample has been steady
    always_ff @(posedge clk) begin
        if (reset) begin
            r_segQ    <= SEG_BLANK;
            r_stabCnt <= '0;
        end else begin
            r_segQ <= w_seg;
            if (w_seg != r_segQ) begin
                r_stabCnt <= STAB_W'(1);
            end else if (r_stabCnt != STAB_MAX) begin
                r_stabCnt <= r_stabCnt + STAB_W'(1);
            end
        end
    end

    // Accept a steady new pattern, publish its code and time the phase since
    always_ff @(posedge clk) begin
        if (reset) begin
            r_accPat   <= SEG_BLANK;
            code       <= CODE_BLANK;
            code_valid <= 1'b0;
            r_phaseCnt <= '0;
        end else begin
            code_valid <= w_accept;
            if (w_accept) begin
                r_accPat   <= r_segQ;
                code       <= w_code;
                r_phaseCnt <= '0;
            end else if (r_phaseCnt != PHASE_MAX) begin
                r_phaseCnt <= r_phaseCnt + PHASE_W'(1);
            end
        end
    end

    // Blink tracking: a fresh acceptance always takes priority over a timeout
    always_comb begin
        w_nextState = r_state;
        w_relatch   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_isBlank) begin
                    w_nextState = ST_LIT;
                    w_relatch   = 1'b1;
                end
            end
            ST_LIT: begin
                if (w_accept) begin
                    if (w_isBlank) begin
                        w_nextState = ST_DARK;
                    end else begin
                        w_nextState = ST_LIT;
                        w_relatch   = 1'b1;
                    end
                end
            end
            ST_DARK, ST_BLINK_DARK: begin
                if (w_accept) begin
                    if (!w_isBlank) begin
                        if ((r_segQ == r_litPat) && w_inWindow) begin
                            w_nextState = ST_BLINK_LIT;
                        end else begin
                            w_nextState = ST_LIT;
                            w_relatch   = 1'b1;
                        end
                    end
                end else if (w_timeout) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_BLINK_LIT: begin
                if (w_accept) begin
                    if (w_isBlank) begin
                        w_nextState = w_inWindow ? ST_BLINK_DARK : ST_DARK;
                    end else begin
                        w_nextState = ST_LIT;
                        w_relatch   = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_nextState = ST_LIT;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Blink state register plus the display-side outputs derived from it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_litPat  <= SEG_BLANK;
            blinking  <= 1'b0;
            disp_code <= CODE_BLANK;
        end else begin
            r_state  <= w_nextState;
            blinking <= (w_nextState == ST_BLINK_LIT) || (w_nextState == ST_BLINK_DARK);
            if (w_relatch) begin
                r_litPat <= r_segQ;
            end
            if (w_accept && !w_isBlank) begin
                disp_code <= w_code;
            end else if ((w_nextState == ST_IDLE) && (r_state != ST_IDLE)) begin
                disp_code <= CODE_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_seg7_pattern_reader.sv
// Scoreboard bench for seg7_pattern_reader: directed segment patterns push
// their hand-computed results into per-DUT queues, and monitors pop and
// compare on every code_valid strobe. A second instance with a longer
// debounce covers the STABLE_CYCLES behaviour.
module tb_seg7_pattern_reader;

    typedef struct {
        logic [4:0] code;
        logic [4:0] disp;
        logic       blink;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [6:0] seg0;
    logic [6:0] seg3;
    logic [4:0] code0, disp0, code3, disp3;
    logic       valid0, blink0, valid3, blink3;

    exp_t q0[$];
    exp_t q3[$];
    int   cycle;
    int   checkCount;
    int   passCount;
    int   lastDrive;

    seg7_pattern_reader #(.STABLE_CYCLES(1), .BLINK_WINDOW(4)) dut (
        .clk(clk), .reset(reset),
        .A(seg0[6]), .B(seg0[5]), .C(seg0[4]), .D(seg0[3]),
        .E(seg0[2]), .F(seg0[1]), .G(seg0[0]),
        .code(code0), .code_valid(valid0), .disp_code(disp0), .blinking(blink0)
    );

    seg7_pattern_reader #(.STABLE_CYCLES(3), .BLINK_WINDOW(4)) dut3 (
        .clk(clk), .reset(reset),
        .A(seg3[6]), .B(seg3[5]), .C(seg3[4]), .D(seg3[3]),
        .E(seg3[2]), .F(seg3[1]), .G(seg3[0]),
        .code(code3), .code_valid(valid3), .disp_code(disp3), .blinking(blink3)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so acceptance latency can be checked exactly
    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive a pattern on the default instance and queue the acceptance it causes
    task automatic applyStimulus(input logic [6:0] pat, input logic [4:0] eCode,
                                 input logic [4:0] eDisp, input logic eBlink);
        exp_t e;
        seg0 = pat;
        e.code = eCode; e.disp = eDisp; e.blink = eBlink; e.cyc = cycle + 2;
        q0.push_back(e);
        lastDrive = cycle;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q0.size() != 0 || q3.size() != 0); i++) begin
            @(negedge clk);
        end
    endtask

    // Monitor for the default instance
    always @(negedge clk) begin
        if (valid0) begin
            if (q0.size() == 0) begin
                checkOutput("dut0_spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                checkOutput("dut0_code", code0, e.code);
                checkOutput("dut0_disp_code", disp0, e.disp);
                checkOutput("dut0_blinking", blink0, e.blink);
                checkOutput("dut0_accept_cycle", cycle, e.cyc);
            end
        end
    end

    // Monitor for the STABLE_CYCLES=3 instance
    always @(negedge clk) begin
        if (valid3) begin
            if (q3.size() == 0) begin
                checkOutput("dut3_spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                checkOutput("dut3_code", code3, e.code);
                checkOutput("dut3_disp_code", disp3, e.disp);
                checkOutput("dut3_blinking", blink3, e.blink);
                checkOutput("dut3_accept_cycle", cycle, e.cyc);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence
    initial begin
        logic [6:0] tblPat  [5];
        logic [4:0] tblCode [5];
        logic [4:0] tblDisp [5];
        checkCount = 0;
        passCount  = 0;
        lastDrive  = 0;
        reset = 1'b1;
        seg0  = 7'b0000000;
        seg3  = 7'b0000000;
        repeat (3) @(negedge clk);
        checkOutput("reset_code", code0, 'h1E);
        checkOutput("reset_disp_code", disp0, 'h1E);
        checkOutput("reset_code_valid", valid0, 0);
        checkOutput("reset_blinking", blink0, 0);
        reset = 1'b0;

        // Blank held after reset: nothing is accepted
        repeat (5) @(negedge clk);
        checkOutput("blank_hold_code", code0, 'h1E);
        checkOutput("blank_hold_disp_code", disp0, 'h1E);
        checkOutput("blank_hold_blinking", blink0, 0);

        // Digit 3, then re-presenting it must not strobe again
        applyStimulus(7'b1111001, 5'h03, 5'h03, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("digit3_held_code", code0, 'h03);

        // MARK / BLANK alternating every cycle
        applyStimulus(7'b1110100, 5'h0C, 5'h0C, 1'b0); @(negedge clk);
        applyStimulus(7'b0000000, 5'h1E, 5'h0C, 1'b0); @(negedge clk);
        applyStimulus(7'b1110100, 5'h0C, 5'h0C, 1'b1); @(negedge clk);
        applyStimulus(7'b0000000, 5'h1E, 5'h0C, 1'b1); @(negedge clk);
        applyStimulus(7'b1110100, 5'h0C, 5'h0C, 1'b1); @(negedge clk);
        applyStimulus(7'b0000000, 5'h1E, 5'h0C, 1'b1);

        // Blank held past the window: drops to idle once the phase count saturates
        repeat (7) @(negedge clk);
        checkOutput("timeout_edge_minus1_cycle", cycle, lastDrive + 7);
        checkOutput("pre_timeout_blinking", blink0, 1);
        checkOutput("pre_timeout_disp_code", disp0, 'h0C);
        @(negedge clk);
        checkOutput("timeout_blinking", blink0, 0);
        checkOutput("timeout_disp_code", disp0, 'h1E);
        checkOutput("timeout_code", code0, 'h1E);

        // Restart blinking, then reset in the middle of it
        applyStimulus(7'b1110100, 5'h0C, 5'h0C, 1'b0); @(negedge clk);
        applyStimulus(7'b0000000, 5'h1E, 5'h0C, 1'b0); @(negedge clk);
        applyStimulus(7'b1110100, 5'h0C, 5'h0C, 1'b1);
        drain();
        checkOutput("preblink_reset_blinking", blink0, 1);
        reset = 1'b1;
        seg0  = 7'b1100111;
        @(negedge clk);
        checkOutput("midblink_reset_code", code0, 'h1E);
        checkOutput("midblink_reset_disp_code", disp0, 'h1E);
        checkOutput("midblink_reset_code_valid", valid0, 0);
        checkOutput("midblink_reset_blinking", blink0, 0);
        reset = 1'b0;
        applyStimulus(7'b1100111, 5'h0B, 5'h0B, 1'b0);
        repeat (3) @(negedge clk);

        // Assorted symbols including two different invalid patterns
        tblPat[0] = 7'b0111110; tblCode[0] = 5'h0A; tblDisp[0] = 5'h0A;
        tblPat[1] = 7'b1111011; tblCode[1] = 5'h09; tblDisp[1] = 5'h09;
        tblPat[2] = 7'b1010101; tblCode[2] = 5'h1F; tblDisp[2] = 5'h1F;
        tblPat[3] = 7'b0000001; tblCode[3] = 5'h1F; tblDisp[3] = 5'h1F;
        tblPat[4] = 7'b0000000; tblCode[4] = 5'h1E; tblDisp[4] = 5'h1F;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(tblPat[i], tblCode[i], tblDisp[i], 1'b0);
            repeat (2) @(negedge clk);
        end

        // Longer debounce: a 2-cycle glitch is ignored, a steady 8 is taken
        seg3 = 7'b0110000;
        repeat (2) @(negedge clk);
        begin
            exp_t e;
            seg3 = 7'b1111111;
            e.code = 5'h08; e.disp = 5'h08; e.blink = 1'b0; e.cyc = cycle + 4;
            q3.push_back(e);
        end
        repeat (6) @(negedge clk);
        checkOutput("dut3_final_code", code3, 'h08);

        drain();
        checkOutput("dut0_pending_expectations", q0.size(), 0);
        checkOutput("dut3_pending_expectations", q3.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
